// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder controller.
// Holds the FSM state encoding and the default operand width.
package serial_add_pkg;

   localparam int SERIAL_ADD_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Bit counter width; a one-bit counter is the floor for the smallest legal WIDTH.
   function automatic int cnt_width(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/my_fadder2.sv
// One-bit full-adder cell, shared with the combinational adder library.
// Used here as the per-cycle datapath of the serial adder.
module my_fadder2 (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full-adder cell stepped over WIDTH cycles with a start/busy/done handshake.
// Optional signed-overflow output `ovf` is built when SERIAL_ADD_OVF_EN is defined.
module serial_adder_ctrl
   import serial_add_pkg::*;
#(
   parameter int WIDTH = SERIAL_ADD_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Ci,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] S,
`ifdef SERIAL_ADD_OVF_EN
   output logic             ovf,
`endif
   output logic             Co
);

   localparam int            CW   = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state;
   state_t           state_nxt;
   logic             load;
   logic             shift_en;
   logic             last_bit;

   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic             carry;
   logic [CW-1:0]    cnt;

   logic             sum_bit;
   logic             cell_co;

   my_fadder2 u_fadder (
      .a  (a_sh[0]),
      .b  (b_sh[0]),
      .ci (carry),
      .s  (sum_bit),
      .co (cell_co)
   );

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      shift_en  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load      = 1'b1;
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            shift_en = 1'b1;
            if (cnt == LAST) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            // Accepting start here gives back-to-back operation at WIDTH+1 cycles per add.
            if (start) begin
               load      = 1'b1;
               state_nxt = SHIFT;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign last_bit = shift_en && (cnt == LAST);

   // NOTE: the shift registers are reset as well, so an aborted add leaves no stale operand bits behind.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_sh  <= '0;
         b_sh  <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         S     <= '0;
         Co    <= 1'b0;
      end else if (load) begin
         a_sh  <= A;
         b_sh  <= B;
         carry <= Ci;
         cnt   <= '0;
         S     <= '0;
         Co    <= 1'b0;
      end else if (shift_en) begin
         a_sh  <= a_sh >> 1;
         b_sh  <= b_sh >> 1;
         carry <= cell_co;
         cnt   <= cnt + 1'b1;
         S     <= {sum_bit, S[WIDTH-1:1]};
         if (last_bit) begin
            Co <= cell_co;
         end
      end
   end

`ifdef SERIAL_ADD_OVF_EN
   // In the last step `carry` is the carry into the MSB and cell_co the final carry-out.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ovf <= 1'b0;
      end else if (load) begin
         ovf <= 1'b0;
      end else if (last_bit) begin
         ovf <= carry ^ cell_co;
      end
   end
`endif

   assign busy = (state == SHIFT);
   assign done = (state == DONE);

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl (WIDTH=8): directed adds, ignored start, abort by reset, back-to-back.
// Checks ovf as well when built with SERIAL_ADD_OVF_EN.
module tb_serial_adder_ctrl;

   typedef struct {
      logic [7:0] s;
      logic       co;
      logic       ovf;
   } exp_t;

   logic       clk   = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic [7:0] A     = 8'h00;
   logic [7:0] B     = 8'h00;
   logic       Ci    = 1'b0;
   logic       busy;
   logic       done;
   logic [7:0] S;
   logic       Co;
`ifdef SERIAL_ADD_OVF_EN
   logic       ovf;
`endif

   int   tests = 0;
   int   fails = 0;
   exp_t q[$];
   exp_t mon_e;
   int   n;
   int   nb;
   int   stray_done;

   serial_adder_ctrl #(.WIDTH(8)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .A     (A),
      .B     (B),
      .Ci    (Ci),
      .busy  (busy),
      .done  (done),
      .S     (S),
`ifdef SERIAL_ADD_OVF_EN
      .ovf   (ovf),
`endif
      .Co    (Co)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!reset && done) begin
         if (q.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
         end else begin
            mon_e = q.pop_front();
            check("result_S", {24'd0, S}, {24'd0, mon_e.s});
            check("result_Co", {31'd0, Co}, {31'd0, mon_e.co});
`ifdef SERIAL_ADD_OVF_EN
            check("result_ovf", {31'd0, ovf}, {31'd0, mon_e.ovf});
`endif
         end
      end
   end

   task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic ci,
                        input logic [7:0] es, input logic eco, input logic eovf, input bit push);
      exp_t e;
      A     = a;
      B     = b;
      Ci    = ci;
      start = 1'b1;
      if (push) begin
         e.s   = es;
         e.co  = eco;
         e.ovf = eovf;
         q.push_back(e);
      end
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Counts negedges up to and including the one where done is seen; nb counts busy samples before it.
   task automatic wait_done(input string name, output int cycles, output int busy_cycles);
      bit got;
      got         = 1'b0;
      cycles      = 0;
      busy_cycles = 0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         cycles++;
         if (done) got = 1'b1;
         else if (busy) busy_cycles++;
      end
      if (!got) check({name, "_done_timeout"}, 32'd0, 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, required $finish before 100us");
      $fatal(1, "watchdog expired");
   end

   initial begin
      #1 reset = 1'b1;
      #2;
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_S", {24'd0, S}, 32'd0);
      check("rst_Co", {31'd0, Co}, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) reset = 1'b0;

      // 0x0F + 0x01: eight busy cycles, done on the ninth.
      issue(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 1'b1);
      wait_done("op1", n, nb);
      check("op1_latency", n, 32'd9);
      check("op1_busy", nb, 32'd8);
      @(negedge clk);
      check("op1_hold_S", {24'd0, S}, 32'h10);
      check("op1_idle_busy", {31'd0, busy}, 32'd0);

      // 0xFF + 0x01 wraps with carry-out.
      issue(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
      wait_done("op2", n, nb);
      check("op2_latency", n, 32'd9);

      // 0x7F + 0x00 + Ci: signed overflow case.
      issue(8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1, 1'b1);
      wait_done("op3", n, nb);
      check("op3_latency", n, 32'd9);
      @(negedge clk);

      // start re-pulsed in the third SHIFT cycle must be ignored.
      issue(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      @(negedge clk);
      A     = 8'h55;
      B     = 8'h00;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      check("op4_still_busy", {31'd0, busy}, 32'd1);
      wait_done("op4", n, nb);
      check("op4_latency", n, 32'd7);
      @(negedge clk);

      // Reset in mid-SHIFT aborts with no done pulse.
      issue(8'h33, 8'h12, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      check("abort_busy_before", {31'd0, busy}, 32'd1);
      #1 reset = 1'b1;
      #1;
      check("abort_S", {24'd0, S}, 32'd0);
      check("abort_Co", {31'd0, Co}, 32'd0);
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_done", {31'd0, done}, 32'd0);
      @(posedge clk);
      @(negedge clk) reset = 1'b0;
      stray_done = 0;
      repeat (12) begin
         @(negedge clk);
         if (done) stray_done++;
      end
      check("abort_no_done", stray_done, 32'd0);
      issue(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 1'b1);
      wait_done("op5", n, nb);
      check("op5_latency", n, 32'd9);
      @(negedge clk);

      // start held high through done: second add starts right after the done cycle.
      issue(8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b1);
      start = 1'b1;
      A     = 8'h01;
      B     = 8'h02;
      Ci    = 1'b0;
      mon_e.s = 8'h03;
      begin
         exp_t e2;
         e2.s   = 8'h03;
         e2.co  = 1'b0;
         e2.ovf = 1'b0;
         q.push_back(e2);
      end
      wait_done("op6a", n, nb);
      check("op6a_latency", n, 32'd9);
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      check("op6_b2b_busy", {31'd0, busy}, 32'd1);
      wait_done("op6b", n, nb);
      check("op6b_latency", n, 32'd8);

      @(negedge clk);
      check("scoreboard_empty", q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
